// File: rtl/mmio_display.sv
// mmio_display: memory-mapped multiplexed 7-segment display and LED register
//   clk, reset         : system clock, asynchronous active-high reset
//   sel, we, addr      : bus select, write enable, byte address (addr[3:2] decoded)
//   wdata, rdata       : write data, registered read data (1-cycle latency)
//   an, seg            : active-low digit anodes and {g,f,e,d,c,b,a} segments
//   led                : active-high LED register output
module mmio_display #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int N_LEDS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic [N_LEDS-1:0]   led
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [31:0] DMASK = N_DIGITS == 8 ? 32'hFFFF_FFFF : (32'h1 << (4 * N_DIGITS)) - 32'h1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0]         data_q, data_d, rdata_q, rdata_d;
  logic [N_DIGITS-1:0] mask_q, mask_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                en_q, en_d, lzb_q, lzb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [1:0]          a;
  logic                wr, rd, wrap, run, blank, show;
  logic [3:0]          nib;
  logic                unused;
  assign a      = addr[3:2];
  assign unused = ^{addr[31:4], addr[1:0], wdata};
  always_comb begin
    wr           = sel && we;
    rd           = sel && !we;
    data_d       = (wr && a == 2'd0) ? wdata : data_q;
    mask_d       = (wr && a == 2'd1) ? wdata[N_DIGITS-1:0] : mask_q;
    led_d        = (wr && a == 2'd2) ? wdata[N_LEDS-1:0] : led_q;
    {lzb_d, en_d} = (wr && a == 2'd3) ? wdata[1:0] : {lzb_q, en_q};
    // Scan only continues while EN stays set; a 0->1 write starts from a cleared state.
    run          = en_q && en_d;
    wrap         = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d        = (run && !wrap) ? cnt_q + 1'b1 : '0;
    idx_d        = !run ? '0 : !wrap ? idx_q : idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1;
    rdata_d      = !rd ? rdata_q :
                   a == 2'd0 ? data_q :
                   a == 2'd1 ? 32'(mask_q) :
                   a == 2'd2 ? 32'(led_q) :
                   {16'h0, 8'(idx_q), 6'h0, lzb_q, en_q};
    nib          = 4'(data_q >> (4 * idx_q));
    // Leading-zero blank: this nibble and every higher one are zero, never for digit 0.
    blank        = lzb_q && idx_q != '0 && ((data_q & DMASK) >> (4 * idx_q)) == 32'h0;
    show         = en_q && mask_q[idx_q] && !blank;
    an           = show ? ~(N_DIGITS'(1) << idx_q) : '1;
    seg          = show ? HEX[nib] : 7'h7F;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      mask_q  <= '1;
      led_q   <= '0;
      en_q    <= 1'b1;
      lzb_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      led_q   <= led_d;
      en_q    <= en_d;
      lzb_q   <= lzb_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end
  assign rdata = rdata_q;
  assign led   = led_q;
endmodule

// File: tb/tb_mmio_display.sv
// tb_mmio_display: self-checking bench for mmio_display with a 4-digit, divide-by-4 scan
module tb_mmio_display;
  logic        clk, reset, sel, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] led;
  int          passed = 0, total = 0;
  logic [31:0] exp_q [$];

  mmio_display #(.N_DIGITS(4), .REFRESH_DIV(4), .N_LEDS(16)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .an(an), .seg(seg), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = $urandom(); addr[3:2] = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
    logic [31:0] x;
    sel = 1'b1; we = 1'b0; addr = $urandom(); addr[3:2] = a;
    exp_q.push_back(e);
    tick();
    sel = 1'b0;
    total++;
    if (exp_q.size() == 0) $display("FAIL %s: scoreboard empty", name);
    else begin
      x = exp_q.pop_front();
      if (rdata !== x) $display("FAIL %s: rdata=%h expected %h", name, rdata, x);
      else passed++;
    end
  endtask

  task automatic restart(input logic lzb);
    wr(2'd3, {30'h0, lzb, 1'b0});
    wr(2'd3, {30'h0, lzb, 1'b1});
  endtask

  task automatic test_reset;
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    total++;
    if ({an, seg, led, rdata} !== {4'b1110, 7'h40, 16'h0, 32'h0})
      $display("FAIL reset: an=%b seg=%h led=%h rdata=%h expected 1110 40 0000 00000000", an, seg, led, rdata);
    else passed++;
  endtask

  task automatic test_scan;
    logic [3:0] ea;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ea = ~(4'b1 << ((k / 4) % 4));
      total++;
      if (an !== ea || seg !== 7'h40) $display("FAIL scan k=%0d: an=%b seg=%h expected %b 40", k, an, seg, ea);
      else passed++;
      tick();
    end
  endtask

  task automatic test_data;
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] es [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    wr(2'd0, 32'h0000_1234);
    restart(1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (an !== ea[k/4] || seg !== es[k/4]) $display("FAIL data k=%0d: an=%b seg=%h expected %b %h", k, an, seg, ea[k/4], es[k/4]);
      else passed++;
      tick();
    end
    rd(2'd3, 32'h0000_0001, "ctrl_idx0");
    rd(2'd0, 32'h0000_1234, "data_read");
    tick(); tick();
    total++;
    if (rdata !== 32'h0000_1234) $display("FAIL rdata_hold: rdata=%h expected 00001234", rdata);
    else passed++;
    rd(2'd1, 32'h0000_000F, "mask_read");
  endtask

  task automatic test_lzb;
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [6:0] es [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    wr(2'd0, 32'h0000_0050);
    restart(1'b1);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (an !== ea[k/4] || seg !== es[k/4]) $display("FAIL lzb k=%0d: an=%b seg=%h expected %b %h", k, an, seg, ea[k/4], es[k/4]);
      else passed++;
      tick();
    end
    rd(2'd3, 32'h0000_0003, "ctrl_lzb");
  endtask

  task automatic test_mask;
    logic [3:0] ea [4] = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
    logic [6:0] es [4] = '{7'h40, 7'h7F, 7'h40, 7'h7F};
    wr(2'd1, 32'h0000_0005);
    restart(1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (an !== ea[k/4] || seg !== es[k/4]) $display("FAIL mask k=%0d: an=%b seg=%h expected %b %h", k, an, seg, ea[k/4], es[k/4]);
      else passed++;
      tick();
    end
    tick(); tick();
    wr(2'd3, 32'h0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (an !== 4'hF || seg !== 7'h7F) $display("FAIL disable k=%0d: an=%b seg=%h expected 1111 7f", k, an, seg);
      else passed++;
      tick();
    end
    rd(2'd3, 32'h0, "ctrl_disabled");
    wr(2'd1, 32'hFFFF_FFF0);
    rd(2'd1, 32'h0, "mask_width");
    wr(2'd1, 32'h0000_000F);
    rd(2'd1, 32'h0000_000F, "mask_restore");
  endtask

  task automatic test_back_to_back;
    wr(2'd0, 32'h0);
    restart(1'b0);
    tick(); tick(); tick();
    wr(2'd0, 32'h0000_0070);
    total++;
    if (an !== 4'b1101 || seg !== 7'h78) $display("FAIL wrap_write: an=%b seg=%h expected 1101 78", an, seg);
    else passed++;
    repeat (4) tick();
    total++;
    if (an !== 4'b1011 || seg !== 7'h40) $display("FAIL no_disturb: an=%b seg=%h expected 1011 40", an, seg);
    else passed++;
    rd(2'd3, 32'h0000_0201, "ctrl_idx2");
  endtask

  task automatic test_led_async_reset;
    wr(2'd2, 32'hFFFF_A5A5);
    total++;
    if (led !== 16'hA5A5) $display("FAIL led: led=%h expected a5a5", led);
    else passed++;
    rd(2'd2, 32'h0000_A5A5, "led_read");
    #3 reset = 1'b1;
    #1;
    total++;
    if ({led, an, seg, rdata} !== {16'h0, 4'b1110, 7'h40, 32'h0})
      $display("FAIL async_reset: led=%h an=%b seg=%h rdata=%h expected 0000 1110 40 00000000", led, an, seg, rdata);
    else passed++;
    @(negedge clk) reset = 1'b0;
    tick();
    rd(2'd1, 32'h0000_000F, "mask_after_reset");
    rd(2'd0, 32'h0, "data_after_reset");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_data();
    test_lzb();
    test_mask();
    test_back_to_back();
    test_led_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
